veririscv_ifu_prefetch: RTL and testbench
=========================================

Name: veririscv_ifu_prefetch

Overview:
Parametrised successor to the single-slot IF stage: an instruction fetch unit with a DEPTH-entry prefetch buffer between instruction RAM and ID. It issues one synchronous-read fetch per cycle while buffer space (counting in-flight reads) exists. It presents {pc, instruction} to ID over a valid/ready handshake so ID can stall. It accepts a redirect (branch/jump/trap) that flushes the buffer and restarts fetch at a new PC.

Parameters:
PC_W, 32, program counter width
DATA_W, 32, instruction width
RAM_AW, 14, instruction RAM word-address width
DEPTH, 4, prefetch buffer entries (power of 2, >=2)
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
instr_ram_rd  out  1  read strobe; data returned next cycle
instr_ram_addr  out  RAM_AW  word address = pc[RAM_AW+1:2]
instr_ram_din  in  DATA_W  read data, valid the cycle after instr_ram_rd
if_valid  out  1  buffer head valid to ID
if_pc  out  PC_W  pc of head entry
if_instruction  out  DATA_W  instruction of head entry
id_ready  in  1  ID accepts head this cycle
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  PC_W  new fetch pc; bits [1:0] ignored (treated as 0)

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, rsp_pending=0, rsp_pc=0, buffer count=0, if_valid=0, instr_ram_rd=0, if_pc=0, if_instruction=0.
- State: fetch_pc; rsp_pending/rsp_pc (read issued last cycle); FIFO of {pc,instr}, count 0..DEPTH.
- pop = if_valid & id_ready. push = rsp_pending & ~redirect_valid; push writes {rsp_pc, instr_ram_din}.
- Issue rule (no redirect): instr_ram_rd = (count + rsp_pending - pop) < DEPTH. On issue: addr from fetch_pc, rsp_pc<=fetch_pc, fetch_pc<=fetch_pc+4, rsp_pending<=1; else rsp_pending<=0. Overflow is therefore impossible; a push at count==DEPTH is an assertion failure.
- Latency: rd at cycle N -> push at N+1 -> if_valid at N+2. Steady state with id_ready=1 gives 1 instr/cycle.
- if_valid = (count!=0) & ~redirect_valid (combinational kill). Outputs are driven from the FIFO head. When count==0, if_pc/if_instruction hold their last value.
- Redirect at cycle R:
  - FIFO cleared (count<=0, pointers reset).
  - The response arriving in R is dropped.
  - instr_ram_rd=1 in R with addr=redirect_pc[RAM_AW+1:2] (bypass); rsp_pc<=redirect_pc, fetch_pc<=redirect_pc+4.
  - First redirected instr has if_valid at R+2.
  - Redirect overrides pop and push in the same cycle.
  - Back-to-back redirects: the last one wins.
- fetch_pc wraps modulo 2^PC_W; addr truncates to RAM_AW bits (RAM aliasing is the integrator's concern).
- FIFO pointers wrap modulo DEPTH. Simultaneous push+pop at full or empty is legal; count is unchanged.
- Reset asserted mid-operation discards all buffered and in-flight fetches. Fetch resumes at RESET_PC the first cycle after rst=1.

Decomposition:
- Shared core package/header: PC_RANGE, DATA_RANGE, INSTR_RAM_ADDR_RANGE, RESET_PC default, instruction width constants.
- One sub-module, veririscv_sync_fifo:
  - Parameters WIDTH=PC_W+DATA_W and DEPTH.
  - Ports: push, pop, flush, head data, count, async active-low rst.
  - Reused later for the LSU store buffer.

Test Plan:
- Reset release, RESET_PC=0, id_ready=1, RAM[i]=i: rd high from cycle 1 with addr 0,1,2,...; if_valid from cycle 3 with pc 0,4,8 and instr 0,1,2, one per cycle.
- id_ready=0 from start, DEPTH=4: exactly 4 reads issued (addr 0..3), then instr_ram_rd=0. count=4, if_valid=1 with head pc 0. Release id_ready: pcs 0,4,8,C delivered, then fetch resumes at pc 0x10.
- Steady stream, redirect_valid=1 with redirect_pc=0x100 at R: if_valid=0 in R and R+1; addr=0x40 in R; if_valid at R+2 with pc 0x100, then 0x104. No old pc appears after R.
- Redirect while full and id_ready=0: buffer emptied, next head pc = redirect_pc, count never exceeds 4.
- Redirect to 0x103: fetch at pc 0x100 (low bits ignored).
- Assert rst=0 asynchronously mid-stream with count=3: if_valid and instr_ram_rd drop immediately (no clock edge). After release, first delivered pc = RESET_PC.

Source files
------------

// File: rtl/veririscv_ifu_prefetch_pkg.sv
// Shared core constants for the VeriRISCV fetch path: PC / instruction widths,
// instruction RAM word-address range and the default reset vector.
package veririscv_ifu_prefetch_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned ILEN                = 32;
    localparam int unsigned INSTR_BYTES         = ILEN / 8;
    localparam int unsigned INSTR_RAM_AW        = 14;

    localparam int unsigned PC_MSB              = XLEN - 1;
    localparam int unsigned PC_LSB              = 0;
    localparam int unsigned DATA_MSB            = ILEN - 1;
    localparam int unsigned DATA_LSB            = 0;
    localparam int unsigned INSTR_RAM_ADDR_MSB  = INSTR_RAM_AW + 1;
    localparam int unsigned INSTR_RAM_ADDR_LSB  = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/veririscv_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; flush has priority over
// push/pop. Storage is not reset, only pointers and count.
module veririscv_sync_fifo
    import veririscv_ifu_prefetch_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN + ILEN,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;
    logic             full;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        push_ok  = push & ~flush;
        pop_ok   = pop & ~flush & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PTR_W wide so the +1 wraps modulo DEPTH.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push_ok && !pop_ok && full));

endmodule

// File: rtl/veririscv_ifu_prefetch.sv
// Instruction fetch unit: one synchronous RAM read per cycle into a DEPTH-entry
// prefetch buffer, valid/ready delivery to ID, and redirect flush/restart.
module veririscv_ifu_prefetch
    import veririscv_ifu_prefetch_pkg::*;
#(
    parameter int unsigned    PC_W     = XLEN,
    parameter int unsigned    DATA_W   = ILEN,
    parameter int unsigned    RAM_AW   = INSTR_RAM_AW,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              instr_ram_rd,
    output logic [RAM_AW-1:0] instr_ram_addr,
    input  logic [DATA_W-1:0] instr_ram_din,
    output logic              if_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [DATA_W-1:0] if_instruction,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = PC_W + DATA_W;

    logic                run_q;
    logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic                rsp_pending_q, rsp_pending_d;
    logic [PC_W-1:0]     rsp_pc_q, rsp_pc_d;
    logic [ENTRY_W-1:0]  hold_q, hold_d;

    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_nonempty;
    logic                push;
    logic                pop;
    logic [CNT_W:0]      occupancy;
    logic [PC_W-1:0]     redirect_aligned;
    logic [ENTRY_W-1:0]  out_entry;

    always_comb begin
        fifo_nonempty    = (fifo_count != '0);
        pop              = fifo_nonempty & ~redirect_valid & id_ready;
        push             = rsp_pending_q & ~redirect_valid;
        // Slots already committed: buffered + in flight, minus what leaves now.
        occupancy        = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(rsp_pending_q)
                         - (CNT_W+1)'(pop);
        redirect_aligned = redirect_pc & ~PC_W'(3);

        instr_ram_rd     = 1'b0;
        instr_ram_addr   = fetch_pc_q[RAM_AW+1:2];
        fetch_pc_d       = fetch_pc_q;
        rsp_pc_d         = rsp_pc_q;
        rsp_pending_d    = 1'b0;

        if (redirect_valid) begin
            instr_ram_rd   = run_q;
            instr_ram_addr = redirect_aligned[RAM_AW+1:2];
            rsp_pc_d       = redirect_aligned;
            rsp_pending_d  = run_q;
            fetch_pc_d     = run_q ? redirect_aligned + PC_W'(INSTR_BYTES)
                                   : redirect_aligned;
        end else if (run_q && (occupancy < (CNT_W+1)'(DEPTH))) begin
            instr_ram_rd   = 1'b1;
            rsp_pc_d       = fetch_pc_q;
            rsp_pending_d  = 1'b1;
            fetch_pc_d     = fetch_pc_q + PC_W'(INSTR_BYTES);
        end

        // Outputs follow the head; with an empty buffer they keep the last head.
        out_entry      = fifo_nonempty ? fifo_head : hold_q;
        hold_d         = out_entry;
        if_valid       = fifo_nonempty & ~redirect_valid;
        if_pc          = out_entry[ENTRY_W-1:DATA_W];
        if_instruction = out_entry[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pending_q <= 1'b0;
            rsp_pc_q      <= '0;
            hold_q        <= '0;
        end else begin
            run_q         <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_pc_q      <= rsp_pc_d;
            hold_q        <= hold_d;
        end
    end

    veririscv_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({rsp_pc_q, instr_ram_din}),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    a_push_not_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_veririscv_ifu_prefetch.sv
// Bench for veririscv_ifu_prefetch: cycle vector table, directed stall /
// redirect / async-reset sequences, and randomized stream vs. a stream model.
module tb_veririscv_ifu_prefetch;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RAM_AW = 14;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              instr_ram_rd;
    logic [RAM_AW-1:0] instr_ram_addr;
    logic [DATA_W-1:0] instr_ram_din = '0;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [DATA_W-1:0] if_instruction;
    logic              id_ready = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    veririscv_ifu_prefetch #(
        .PC_W     (PC_W),
        .DATA_W   (DATA_W),
        .RAM_AW   (RAM_AW),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_ram_rd   (instr_ram_rd),
        .instr_ram_addr (instr_ram_addr),
        .instr_ram_din  (instr_ram_din),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Instruction RAM with RAM[i] = i, one-cycle read latency.
    always @(posedge clk) begin
        if (instr_ram_rd) instr_ram_din <= DATA_W'(instr_ram_addr);
    end

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_rd;
        logic [13:0] e_addr;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc,
                                input logic e_vld, input logic [31:0] e_pc,
                                input logic e_rd, input logic [13:0] e_addr);
        vec_t v;
        v.rdy = 1'b1; v.redir = redir; v.rpc = rpc;
        v.e_vld = e_vld; v.e_pc = e_pc; v.e_rd = e_rd; v.e_addr = e_addr;
        return v;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        return {18'b0, p[15:2]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Leaves the bench at posedge+1 of cycle 0 (first cycle with rst released).
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(posedge clk); #1;
        chk("reset_if_valid", 64'(if_valid), 64'd0);
        chk("reset_rd", 64'(instr_ram_rd), 64'd0);
        chk("reset_if_pc", 64'(if_pc), 64'd0);
        chk("reset_if_instr", 64'(if_instruction), 64'd0);
        rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd;
        int k;
        bit first;
        bit found;
        logic [31:0] exp_pc;
        logic [31:0] nf;
        int ndel;

        tbl[0]  = mk(0, 32'h0,   0, 32'h0,   0, 14'h0);
        tbl[1]  = mk(0, 32'h0,   0, 32'h0,   1, 14'h0);
        tbl[2]  = mk(0, 32'h0,   0, 32'h0,   1, 14'h1);
        tbl[3]  = mk(0, 32'h0,   1, 32'h0,   1, 14'h2);
        tbl[4]  = mk(0, 32'h0,   1, 32'h4,   1, 14'h3);
        tbl[5]  = mk(0, 32'h0,   1, 32'h8,   1, 14'h4);
        tbl[6]  = mk(1, 32'h100, 0, 32'h0,   1, 14'h40);
        tbl[7]  = mk(0, 32'h0,   0, 32'h0,   1, 14'h41);
        tbl[8]  = mk(0, 32'h0,   1, 32'h100, 1, 14'h42);
        tbl[9]  = mk(0, 32'h0,   1, 32'h104, 1, 14'h43);
        tbl[10] = mk(1, 32'h103, 0, 32'h0,   1, 14'h40);
        tbl[11] = mk(0, 32'h0,   0, 32'h0,   1, 14'h41);
        tbl[12] = mk(0, 32'h0,   1, 32'h100, 1, 14'h42);
        tbl[13] = mk(0, 32'h0,   1, 32'h104, 1, 14'h43);

        // Vector table: stream from reset, redirect to 0x100, redirect to 0x103.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            id_ready       = tbl[i].rdy;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("vec%0d_if_valid", i), 64'(if_valid), 64'(tbl[i].e_vld));
            chk($sformatf("vec%0d_rd", i), 64'(instr_ram_rd), 64'(tbl[i].e_rd));
            if (tbl[i].e_rd)
                chk($sformatf("vec%0d_addr", i), 64'(instr_ram_addr), 64'(tbl[i].e_addr));
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d_pc", i), 64'(if_pc), 64'(tbl[i].e_pc));
                chk($sformatf("vec%0d_instr", i), 64'(if_instruction), 64'(ram_word(tbl[i].e_pc)));
            end
            next_cycle();
        end
        redirect_valid = 1'b0;

        // Stall from reset: exactly DEPTH reads, then drain and resume at 0x10.
        do_reset();
        nrd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (instr_ram_rd) begin
                chk("stall_addr", 64'(instr_ram_addr), 64'(nrd));
                nrd++;
            end
            next_cycle();
        end
        chk("stall_reads", 64'(nrd), 64'(DEPTH));
        chk("stall_if_valid", 64'(if_valid), 64'd1);
        chk("stall_head_pc", 64'(if_pc), 64'h0);
        id_ready = 1'b1;
        first = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ram_rd && first) begin
                chk("resume_addr", 64'(instr_ram_addr), 64'h4);
                first = 1'b0;
            end
            if (if_valid) begin
                if (k < 6) chk($sformatf("drain_pc%0d", k), 64'(if_pc), 64'(4 * k));
                k++;
            end
            next_cycle();
        end
        chk("drain_count_ge6", 64'(k >= 6), 64'd1);

        // Redirect while full and stalled.
        do_reset();
        for (int i = 0; i < 10; i++) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        chk("full_redir_kill", 64'(if_valid), 64'd0);
        chk("full_redir_rd", 64'(instr_ram_rd), 64'd1);
        chk("full_redir_addr", 64'(instr_ram_addr), 64'h80);
        nrd = 1;
        next_cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (instr_ram_rd) begin
                chk("full_redir_seq_addr", 64'(instr_ram_addr), 64'(32'h80 + nrd));
                nrd++;
            end
            next_cycle();
        end
        chk("full_redir_reads", 64'(nrd), 64'(DEPTH));
        chk("full_redir_valid", 64'(if_valid), 64'd1);
        chk("full_redir_head_pc", 64'(if_pc), 64'h200);
        chk("full_redir_head_instr", 64'(if_instruction), 64'h80);

        // Async reset with three entries buffered.
        do_reset();
        for (int i = 0; i < 10; i++) next_cycle();
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) next_cycle();
        chk("pre_areset_rd", 64'(instr_ram_rd), 64'd1);
        chk("pre_areset_valid", 64'(if_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("areset_valid_drop", 64'(if_valid), 64'd0);
        chk("areset_rd_drop", 64'(instr_ram_rd), 64'd0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (if_valid) begin
                found = 1'b1;
                chk("areset_first_pc", 64'(if_pc), 64'h0);
            end
            next_cycle();
        end
        chk("areset_delivery_seen", 64'(found), 64'd1);

        // Randomized traffic against an in-order stream model.
        do_reset();
        exp_pc = 32'h0;
        nf = 32'h0;
        ndel = 0;
        for (int i = 0; i < 3000; i++) begin
            id_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = (i > 2) && ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            @(negedge clk);
            if (redirect_valid) begin
                chk("rnd_redir_kill", 64'(if_valid), 64'd0);
                chk("rnd_redir_rd", 64'(instr_ram_rd), 64'd1);
                chk("rnd_redir_addr", 64'(instr_ram_addr), 64'(ram_word(redirect_pc)));
                exp_pc = redirect_pc & ~32'h3;
                nf = exp_pc + 32'h4;
            end else begin
                if (instr_ram_rd) begin
                    chk("rnd_fetch_addr", 64'(instr_ram_addr), 64'(ram_word(nf)));
                    nf = nf + 32'h4;
                end
                if (if_valid && id_ready) begin
                    chk("rnd_pc", 64'(if_pc), 64'(exp_pc));
                    chk("rnd_instr", 64'(if_instruction), 64'(ram_word(exp_pc)));
                    exp_pc = exp_pc + 32'h4;
                    ndel++;
                end
            end
            next_cycle();
        end
        redirect_valid = 1'b0;
        chk("rnd_throughput", 64'(ndel > 1000), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
